// File: rtl/clock_time_sequencer.sv
// BCD time-of-day sequencer with alarm, Avalon-MM register slave and level irq.
// Define CLOCK_SEQ_12H_EN for 12-hour mode (hours bit7 = PM), else 24-hour mode.
//
// state   | meaning
// ARMED   | waiting for the time to reach the alarm minute
// RINGING | alarm sounding; counts down ALARM_RING_SECS ticks
module clock_time_sequencer #(
    parameter int TICK_DIV        = 50000000,
    parameter int ALARM_RING_SECS = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  hours_bcd,
    output logic [7:0]  minutes_bcd,
    output logic [7:0]  seconds_bcd,
    output logic        alarm_active,
    output logic        irq
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RW = $clog2(ALARM_RING_SECS + 1);

    typedef enum logic {
        ARMED   = 1'b0,
        RINGING = 1'b1
    } state_t;

    function automatic logic [7:0] inc_bcd(input logic [7:0] v);
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        else                return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic min_sec_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
    endfunction

`ifdef CLOCK_SEQ_12H_EN
    localparam logic [7:0] HH_RESET = 8'h12;

    function automatic logic hours_ok(input logic [7:0] v);
        return (v[6:5] == 2'b00) &&
               ((!v[4] && (v[3:0] != 4'd0) && (v[3:0] <= 4'd9)) ||
                ( v[4] && (v[3:0] <= 4'd2)));
    endfunction

    // PM flips on the 11 -> 12 step, so 12 belongs to the following half-day
    function automatic logic [7:0] inc_hours(input logic [7:0] v);
        logic [7:0] n;
        if (v[4:0] == 5'h11)      return {~v[7], 2'b00, 5'h12};
        else if (v[4:0] == 5'h12) return {v[7], 2'b00, 5'h01};
        else begin
            n = inc_bcd({3'b000, v[4:0]});
            return {v[7], 2'b00, n[4:0]};
        end
    endfunction
`else
    localparam logic [7:0] HH_RESET = 8'h00;

    function automatic logic hours_ok(input logic [7:0] v);
        return (v[3:0] <= 4'd9) &&
               ((v[7:4] <= 4'd1) || ((v[7:4] == 4'd2) && (v[3:0] <= 4'd3)));
    endfunction

    function automatic logic [7:0] inc_hours(input logic [7:0] v);
        return (v == 8'h23) ? 8'h00 : inc_bcd(v);
    endfunction
`endif

    logic [23:0]   time_q, time_d;
    logic [15:0]   alarm_q, alarm_d;
    logic [2:0]    ctrl_q, ctrl_d;
    logic          pending_q, pending_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [RW-1:0] ring_cnt_q, ring_cnt_d;
    logic [31:0]   readdata_q, readdata_d;
    state_t        state_q, state_d;

    logic        wr, time_wr, alarm_wr, stop_w1c, clr_pend, set_pend;
    logic        tick, tick_eff, ring_hit;
    logic [23:0] new_time;
    logic [7:0]  unused_wdata;

    assign unused_wdata = writedata[31:24];

    always_comb begin
        time_d     = time_q;
        alarm_d    = alarm_q;
        ctrl_d     = ctrl_q;
        presc_d    = presc_q;
        ring_cnt_d = ring_cnt_q;
        state_d    = state_q;
        set_pend   = 1'b0;

        wr       = chipselect & ~write_n;
        time_wr  = wr && (address == 2'd0) && hours_ok(writedata[23:16]) &&
                   min_sec_ok(writedata[15:8]) && min_sec_ok(writedata[7:0]);
        alarm_wr = wr && (address == 2'd1) && hours_ok(writedata[15:8]) &&
                   min_sec_ok(writedata[7:0]);
        stop_w1c = wr && (address == 2'd3) && writedata[0];
        clr_pend = wr && (address == 2'd3) && writedata[1];

        tick     = ctrl_q[0] && (presc_q == PW'(TICK_DIV - 1));
        // a valid TIME write in the tick cycle swallows the tick entirely
        tick_eff = tick && !time_wr;

        new_time[7:0]   = (time_q[7:0] == 8'h59) ? 8'h00 : inc_bcd(time_q[7:0]);
        new_time[15:8]  = time_q[15:8];
        new_time[23:16] = time_q[23:16];
        if (time_q[7:0] == 8'h59) begin
            new_time[15:8] = (time_q[15:8] == 8'h59) ? 8'h00 : inc_bcd(time_q[15:8]);
            if (time_q[15:8] == 8'h59) new_time[23:16] = inc_hours(time_q[23:16]);
        end

        if (time_wr)        presc_d = '0;
        else if (ctrl_q[0]) presc_d = tick ? '0 : presc_q + PW'(1);

        if (time_wr)       time_d = writedata[23:0];
        else if (tick_eff) time_d = new_time;

        if (alarm_wr) alarm_d = writedata[15:0];
        if (wr && (address == 2'd2)) ctrl_d = writedata[2:0];

        ring_hit = tick_eff && ctrl_q[1] && (new_time[23:8] == alarm_q) &&
                   (new_time[7:0] == 8'h00);

        case (state_q)
            ARMED: begin
                if (ring_hit) begin
                    state_d    = RINGING;
                    ring_cnt_d = RW'(ALARM_RING_SECS);
                    set_pend   = 1'b1;
                end
            end
            RINGING: begin
                if (stop_w1c || !ctrl_q[1]) begin
                    state_d = ARMED;
                end else if (tick_eff) begin
                    ring_cnt_d = ring_cnt_q - RW'(1);
                    if (ring_cnt_q <= RW'(1)) state_d = ARMED;
                end
            end
            default: state_d = ARMED;
        endcase

        if (set_pend)      pending_d = 1'b1;
        else if (clr_pend) pending_d = 1'b0;
        else               pending_d = pending_q;

        case (address)
            2'd0:    readdata_d = {8'h00, time_q};
            2'd1:    readdata_d = {16'h0000, alarm_q};
            2'd2:    readdata_d = {29'd0, ctrl_q};
            default: readdata_d = {30'd0, pending_q, (state_q == RINGING)};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            time_q     <= {HH_RESET, 16'h0000};
            alarm_q    <= '0;
            ctrl_q     <= '0;
            pending_q  <= 1'b0;
            presc_q    <= '0;
            ring_cnt_q <= '0;
            readdata_q <= '0;
            state_q    <= ARMED;
        end else begin
            time_q     <= time_d;
            alarm_q    <= alarm_d;
            ctrl_q     <= ctrl_d;
            pending_q  <= pending_d;
            presc_q    <= presc_d;
            ring_cnt_q <= ring_cnt_d;
            readdata_q <= readdata_d;
            state_q    <= state_d;
        end
    end

    assign readdata     = readdata_q;
    assign hours_bcd    = time_q[23:16];
    assign minutes_bcd  = time_q[15:8];
    assign seconds_bcd  = time_q[7:0];
    assign alarm_active = (state_q == RINGING);
    assign irq          = pending_q & ctrl_q[2];

endmodule
